// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates one signed partial sum per output pixel per input channel into
//   an OFM_SIZE x OFM_SIZE buffer. On the last input channel the finished pixel
//   is sent out through a valid/ready register. It tracks pixel, channel and
//   filter progress and pulses done after the final pixel of the last filter.
//
// Optional feature: define RELU_EN to clamp negative output pixels to zero.
//   Buffer accumulation is unaffected by this option.
//
// Ports
//   clk1        sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_conv  one-cycle start/restart pulse (accepted in any state)
//   psum_valid  partial-sum beat present (no backpressure to the PE array)
//   psum_data   signed partial sum, DATA_W bits
//   ofm_valid   output pixel valid
//   ofm_ready   downstream accepts the output pixel
//   ofm_data    accumulated pixel, ACC_W bits, signed
//   ofm_filter  filter index of the output pixel
//   ofm_last    pixel is the last pixel of its filter
//   busy        high while in ACCUM
//   done        high for the one cycle spent in DONE
//   ovf_err     sticky: an output pixel was dropped
//   dbg_state   current FSM state (0 IDLE, 1 ACCUM, 2 DONE)
//
// Handshake: a pixel transfers in every cycle where ofm_valid && ofm_ready at
//   the rising edge. While ofm_valid is high, ofm_data/ofm_filter/ofm_last are
//   held stable. ofm_valid never waits on ofm_ready to assert. The input side
//   has no ready: each psum_valid beat in ACCUM is consumed in that cycle.
module psum_accumulator #(
    parameter int KERNEL_SIZE = 4,
    parameter int IFM_SIZE    = 9,
    parameter int CI          = 3,
    parameter int CO          = 4,
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 32
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     start_conv,
    input  logic                     psum_valid,
    input  logic signed [DATA_W-1:0] psum_data,
    output logic                     ofm_valid,
    input  logic                     ofm_ready,
    output logic signed [ACC_W-1:0]  ofm_data,
    output logic [7:0]               ofm_filter,
    output logic                     ofm_last,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf_err,
    output logic [1:0]               dbg_state
);

    localparam int OFM_SIZE = IFM_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX     = OFM_SIZE * OFM_SIZE;
    localparam int PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CH_W     = (CI > 1) ? $clog2(CI) : 1;
    localparam int FLT_W    = (CO > 1) ? $clog2(CO) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CI - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(CO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PIX_W-1:0] pix;
    logic [CH_W-1:0]  ch;
    logic [FLT_W-1:0] flt;

    logic signed [ACC_W-1:0] mem [NPIX];
    logic signed [ACC_W-1:0] mem_rd;
    logic signed [ACC_W-1:0] psum_ext;
    logic signed [ACC_W-1:0] result;
    logic signed [ACC_W-1:0] result_out;

    logic accept;
    logic pix_wrap, ch_wrap, final_beat;
    logic result_valid, out_load, out_drop;

    // start_conv takes priority over a coincident beat: the beat is discarded
    // so the restarted pass begins cleanly at pixel 0.
    assign accept     = psum_valid && (state == ACCUM) && !start_conv;
    assign pix_wrap   = (pix == PIX_LAST);
    assign ch_wrap    = pix_wrap && (ch == CH_LAST);
    assign final_beat = ch_wrap && (flt == FLT_LAST);

    assign psum_ext = ACC_W'(psum_data);
    assign mem_rd   = mem[pix];

    always_comb begin
        result = mem_rd + psum_ext;
        if (CI == 1) result = psum_ext;
    end

`ifdef RELU_EN
    assign result_out = result[ACC_W-1] ? '0 : result;
`else
    assign result_out = result;
`endif

    // A result can load when the register is empty or being drained in the
    // same cycle; otherwise it is lost and flagged.
    assign result_valid = accept && (ch == CH_LAST);
    assign out_load     = result_valid && (!ofm_valid || ofm_ready);
    assign out_drop     = result_valid && ofm_valid && !ofm_ready;

    // FSM state register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state and outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    state_next = IDLE;
            ACCUM: begin
                busy = 1'b1;
                if (accept && final_beat) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (start_conv) state_next = ACCUM;
    end

    assign dbg_state = state;

    // Pixel / channel / filter progress counters
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pix <= '0;
            ch  <= '0;
            flt <= '0;
        end else if (start_conv) begin
            pix <= '0;
            ch  <= '0;
            flt <= '0;
        end else if (accept) begin
            pix <= pix_wrap ? '0 : pix + 1'b1;
            if (pix_wrap) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            if (ch_wrap)  flt <= (flt == FLT_LAST) ? '0 : flt + 1'b1;
        end
    end

    // Accumulation buffer: never reset, first channel overwrites stale data.
    // The last channel only reads, its sum goes straight to the output.
    always_ff @(posedge clk1) begin
        if (accept && (ch != CH_LAST)) begin
            if (ch == '0) mem[pix] <= psum_ext;
            else          mem[pix] <= mem_rd + psum_ext;
        end
    end

    // Output register and sticky overflow flag
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ofm_valid  <= 1'b0;
            ofm_data   <= '0;
            ofm_filter <= '0;
            ofm_last   <= 1'b0;
            ovf_err    <= 1'b0;
        end else if (start_conv) begin
            ofm_valid <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (out_load) begin
                ofm_valid  <= 1'b1;
                ofm_data   <= result_out;
                ofm_filter <= 8'(flt);
                ofm_last   <= pix_wrap;
            end else if (ofm_valid && ofm_ready) begin
                ofm_valid <= 1'b0;
            end
            if (out_drop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
module tb_psum_accumulator;

  localparam int NPIX = 36;

  logic        clk1;
  logic        rst_n, start_conv, psum_valid, ofm_ready;
  logic [15:0] psum_data;
  logic        ofm_valid, ofm_last, busy, done, ovf_err;
  logic [31:0] ofm_data;
  logic [7:0]  ofm_filter;
  logic [1:0]  dbg_state;

  logic        rst1_n, start_conv1, psum_valid1, ofm_ready1;
  logic [15:0] psum_data1;
  logic        ofm_valid1, ofm_last1, busy1, done1, ovf_err1;
  logic [31:0] ofm_data1;
  logic [7:0]  ofm_filter1;
  logic [1:0]  dbg_state1;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [40:0] exp_q[$];

  typedef struct {
    logic signed [15:0] v0, v1, v2;
    logic signed [31:0] sum;
  } vec_t;
  vec_t vt[6];

  psum_accumulator dut (
    .clk1(clk1), .rst_n(rst_n), .start_conv(start_conv),
    .psum_valid(psum_valid), .psum_data(psum_data),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data),
    .ofm_filter(ofm_filter), .ofm_last(ofm_last), .busy(busy),
    .done(done), .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  psum_accumulator #(.CI(1), .CO(1)) dut1 (
    .clk1(clk1), .rst_n(rst1_n), .start_conv(start_conv1),
    .psum_valid(psum_valid1), .psum_data(psum_data1),
    .ofm_valid(ofm_valid1), .ofm_ready(ofm_ready1), .ofm_data(ofm_data1),
    .ofm_filter(ofm_filter1), .ofm_last(ofm_last1), .busy(busy1),
    .done(done1), .ovf_err(ovf_err1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic [31:0] relu_f(input logic signed [31:0] v);
`ifdef RELU_EN
    return (v < 0) ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic beat(input logic [15:0] d);
    tick();
    start_conv = 1'b0;
    psum_valid = 1'b1;
    psum_data  = d;
  endtask

  task automatic idle();
    tick();
    start_conv = 1'b0;
    psum_valid = 1'b0;
  endtask

  task automatic start();
    tick();
    start_conv = 1'b1;
    psum_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [7:0] f, input logic l);
    exp_q.push_back({l, f, d});
  endtask

  // scoreboard: every transfer on the main DUT must match the next expectation
  always @(negedge clk1) begin
    if (ofm_valid && ofm_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %0h expected none", {ofm_last, ofm_filter, ofm_data});
      end else begin
        check("ofm_beat", {ofm_last, ofm_filter, ofm_data}, exp_q.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  initial begin
    vt[0] = '{16'sd5,      -16'sd2,      -16'sd10,     -32'sd7};
    vt[1] = '{16'sd100,    16'sd200,     16'sd300,     32'sd600};
    vt[2] = '{-16'sd32768, -16'sd32768,  -16'sd32768,  -32'sd98304};
    vt[3] = '{16'sd32767,  16'sd32767,   16'sd32767,   32'sd98301};
    vt[4] = '{16'sd0,      16'sd0,       16'sd0,       32'sd0};
    vt[5] = '{-16'sd1,     16'sd1,       -16'sd1,      -32'sd1};

    rst_n = 0; rst1_n = 0; start_conv = 0; psum_valid = 0; psum_data = 0; ofm_ready = 1;
    start_conv1 = 0; psum_valid1 = 0; psum_data1 = 0; ofm_ready1 = 1;
    repeat (3) tick();
    rst_n = 1; rst1_n = 1;

    // reset state
    @(negedge clk1);
    check("rst_valid",  ofm_valid, 0);
    check("rst_data",   ofm_data, 0);
    check("rst_filter", ofm_filter, 0);
    check("rst_last",   ofm_last, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_ovf",    ovf_err, 0);
    check("rst_state",  dbg_state, 0);

    // full layer of unit beats
    for (int j = 0; j < 144; j++) push_exp(relu_f(3), 8'(j / NPIX), (j % NPIX) == NPIX - 1);
    start();
    idle();
    @(negedge clk1);
    check("start_busy", busy, 1);
    for (int i = 0; i < 432; i++) beat(16'd1);
    idle();
    @(negedge clk1);
    check("done_pulse", done, 1);
    check("done_busy",  busy, 0);
    check("done_state", dbg_state, 2);
    tick();
    @(negedge clk1);
    check("done_clear", done, 0);
    check("idle_state", dbg_state, 0);
    check("done_count", done_cnt, 1);
    check("layer_drained", exp_q.size(), 0);

    // beats in IDLE are ignored
    beat(16'd5);
    beat(16'd5);
    idle();
    tick();
    @(negedge clk1);
    check("idle_ignore_valid", ofm_valid, 0);
    check("idle_ignore_state", dbg_state, 0);

    // table-driven pixel sums, one filter
    for (int p = 0; p < NPIX; p++)
      push_exp((p < 6) ? relu_f(vt[p].sum) : 32'd0, 8'd0, p == NPIX - 1);
    start();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < NPIX; p++) begin
        logic [15:0] d;
        d = 16'd0;
        if (p < 6) d = (c == 0) ? vt[p].v0 : (c == 1) ? vt[p].v1 : vt[p].v2;
        beat(d);
        if (c == 2 && p == 0) begin
          @(negedge clk1);
          check("lat_before", ofm_valid, 0);
        end
        if (c == 2 && p == 1) begin
          @(negedge clk1);
          check("lat_valid", ofm_valid, 1);
          check("lat_data",  ofm_data, relu_f(-32'sd7));
        end
      end
    end
    idle();
    tick();
    tick();
    check("table_drained", exp_q.size(), 0);
    check("table_busy", busy, 1);

    // overflow: two results while downstream stalls
    start();
    idle();
    ofm_ready = 0;
    push_exp(32'd4, 8'd0, 1'b0);
    for (int i = 0; i < 2 * NPIX; i++) beat(16'd0);
    beat(16'd4);
    beat(16'd9);
    idle();
    @(negedge clk1);
    check("ovf_hold_valid", ofm_valid, 1);
    check("ovf_hold_data",  ofm_data, 4);
    check("ovf_set",        ovf_err, 1);
    repeat (3) tick();
    @(negedge clk1);
    check("ovf_hold_data2", ofm_data, 4);
    check("ovf_sticky",     ovf_err, 1);
    tick();
    ofm_ready = 1;
    tick();
    @(negedge clk1);
    check("ovf_drop_valid", ofm_valid, 0);
    check("ovf_sticky2",    ovf_err, 1);
    check("ovf_drained",    exp_q.size(), 0);

    // accept and load in the same cycle
    start();
    idle();
    @(negedge clk1);
    check("start_clears_ovf", ovf_err, 0);
    ofm_ready = 0;
    push_exp(32'd7, 8'd0, 1'b0);
    push_exp(32'd9, 8'd0, 1'b0);
    for (int i = 0; i < 2 * NPIX; i++) beat(16'd0);
    beat(16'd7);
    beat(16'd9);
    ofm_ready = 1;
    idle();
    @(negedge clk1);
    check("simul_valid", ofm_valid, 1);
    check("simul_data",  ofm_data, 9);
    check("simul_ovf",   ovf_err, 0);
    tick();
    tick();
    check("simul_drained", exp_q.size(), 0);

    // restart after 50 beats: only the new beats count
    start();
    for (int i = 0; i < 50; i++) beat(16'd7);
    start();
    push_exp(32'd66, 8'd0, 1'b0);
    for (int p = 1; p < NPIX; p++) push_exp(32'd3, 8'd0, p == NPIX - 1);
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < NPIX; p++)
        beat((p == 0) ? 16'(11 * (c + 1)) : 16'd1);
    idle();
    tick();
    tick();
    check("restart_drained", exp_q.size(), 0);

    // CI=1, CO=1 instance with a mid-stream reset
    tick();
    start_conv1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start_conv1 = 0;
      psum_valid1 = 1;
      psum_data1  = -16'sd3;
      if (i > 0) begin
        @(negedge clk1);
        check("ci1_valid",  ofm_valid1, 1);
        check("ci1_data",   ofm_data1, relu_f(-32'sd3));
        check("ci1_filter", ofm_filter1, 0);
        check("ci1_last",   ofm_last1, 0);
      end
    end
    tick();
    #2;
    rst1_n = 0;
    #1;
    check("arst_valid", ofm_valid1, 0);
    check("arst_data",  ofm_data1, 0);
    check("arst_last",  ofm_last1, 0);
    check("arst_busy",  busy1, 0);
    check("arst_done",  done1, 0);
    check("arst_ovf",   ovf_err1, 0);
    check("arst_state", dbg_state1, 0);
    tick();
    rst1_n = 1;
    tick();
    tick();
    @(negedge clk1);
    check("arst_idle_valid", ofm_valid1, 0);
    check("arst_idle_state", dbg_state1, 0);
    psum_valid1 = 0;

    check("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
